pc_fetch_sequencer: RTL and testbench

Owns the architectural program counter and fetches instructions from instruction memory over a req/ready handshake. Presents each fetched instruction and its PC to decode over a valid/ready handshake. The PC it presents (inst_pc) drives the branch adder's pc input, and the adder's branch_addr result returns here as the redirect target. Non-pipelined: at most one fetch outstanding and one instruction held.

---
 rtl/pc_fetch_sequencer.sv | 103 ++++++++++
 tb/tb_pc_fetch_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and single-entry fetch sequencer: fetches one instruction
// at a time from instruction memory and holds it for decode until accepted or redirected.
module pc_fetch_sequencer #(
    parameter int INST_ADDR_WIDTH = 16,
    parameter int INST_WIDTH      = 16,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req,
    output logic [INST_ADDR_WIDTH-1:0] imem_addr,
    input  logic                       imem_ready,
    input  logic [INST_WIDTH-1:0]      imem_data,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [INST_WIDTH-1:0]      inst_out,
    output logic [INST_ADDR_WIDTH-1:0] inst_pc,
    input  logic                       branch_taken,
    input  logic [INST_ADDR_WIDTH-1:0] branch_addr,
    output logic                       flush,
    output logic [1:0]                 state_dbg
);

    // Handshakes: a fetch completes on an edge with imem_req && imem_ready; decode
    // accepts on an edge with inst_valid && inst_ready. Neither side may retract early.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        HOLD     = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    state_t                     state;
    logic [INST_ADDR_WIDTH-1:0] pc;

    assign imem_addr = pc;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            imem_req   <= 1'b0;
            inst_valid <= 1'b0;
            inst_out   <= '0;
            inst_pc    <= '0;
            flush      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    imem_req <= 1'b1;
                    state    <= FETCH;
                end
                FETCH: begin
                    if (branch_taken) begin
                        // Any data returned alongside the redirect is dropped.
                        pc         <= branch_addr;
                        imem_req   <= 1'b0;
                        inst_valid <= 1'b0;
                        flush      <= 1'b1;
                        state      <= REDIRECT;
                    end else if (imem_ready) begin
                        inst_out   <= imem_data;
                        inst_pc    <= pc;
                        inst_valid <= 1'b1;
                        pc         <= pc + 1'b1;
                        imem_req   <= 1'b0;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (branch_taken) begin
                        pc         <= branch_addr;
                        inst_valid <= 1'b0;
                        flush      <= 1'b1;
                        state      <= REDIRECT;
                    end else if (inst_ready) begin
                        inst_valid <= 1'b0;
                        imem_req   <= 1'b1;
                        state      <= FETCH;
                    end
                end
                REDIRECT: begin
                    // A newer branch replaces the pending target and extends the flush.
                    if (branch_taken) begin
                        pc <= branch_addr;
                    end else begin
                        flush    <= 1'b0;
                        imem_req <= 1'b1;
                        state    <= FETCH;
                    end
                end
                default: begin
                    imem_req   <= 1'b0;
                    inst_valid <= 1'b0;
                    flush      <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios plus random traffic, checked against
// a flag-based behavioural model and a queue of instructions decode should receive.
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [15:0] imem_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [15:0] inst_out;
    logic [15:0] inst_pc;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_addr = '0;
    logic        flush;
    logic [1:0]  state_dbg;

    logic        w_imem_req;
    logic [15:0] w_imem_addr;
    logic        w_inst_valid;
    logic [15:0] w_inst_out;
    logic [15:0] w_inst_pc;
    logic        w_flush;
    logic [1:0]  w_state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pc_fetch_sequencer #(.INST_ADDR_WIDTH(16), .INST_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_data(imem_data), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc),
        .branch_taken(branch_taken), .branch_addr(branch_addr), .flush(flush),
        .state_dbg(state_dbg)
    );

    pc_fetch_sequencer #(.INST_ADDR_WIDTH(16), .INST_WIDTH(16), .RESET_PC(16'hFFFF)) dut_w (
        .clk(clk), .rst(rst), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ready(imem_ready), .imem_data(imem_data), .inst_valid(w_inst_valid),
        .inst_ready(inst_ready), .inst_out(w_inst_out), .inst_pc(w_inst_pc),
        .branch_taken(branch_taken), .branch_addr(branch_addr), .flush(w_flush),
        .state_dbg(w_state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: what the sequencer is doing, as independent flags.
    int  m_pc;
    bit  m_req, m_valid, m_flush;
    int  m_inst, m_ipc;
    logic [31:0] exp_q[$];

    task automatic model_reset();
        m_pc = 0; m_req = 0; m_valid = 0; m_flush = 0; m_inst = 0; m_ipc = 0;
        exp_q.delete();
    endtask

    task automatic model_edge();
        if (m_valid && inst_ready) exp_q.push_back({m_ipc[15:0], m_inst[15:0]});
        if (!m_req && !m_valid && !m_flush) begin
            m_req = 1;
        end else if (branch_taken) begin
            m_pc = int'(branch_addr); m_req = 0; m_valid = 0; m_flush = 1;
        end else if (m_flush) begin
            m_flush = 0; m_req = 1;
        end else if (m_req && imem_ready) begin
            m_inst = int'(imem_data); m_ipc = m_pc; m_pc = (m_pc + 1) % 65536;
            m_valid = 1; m_req = 0;
        end else if (m_valid && inst_ready) begin
            m_valid = 0; m_req = 1;
        end
    endtask

    task automatic compare_all();
        check("imem_req",   32'(imem_req),   32'(m_req));
        check("imem_addr",  32'(imem_addr),  m_pc);
        check("inst_valid", 32'(inst_valid), 32'(m_valid));
        check("flush",      32'(flush),      32'(m_flush));
        check("inst_out",   32'(inst_out),   m_inst);
        check("inst_pc",    32'(inst_pc),    m_ipc);
    endtask

    task automatic step(input bit ir, input bit dr, input bit bt,
                        input logic [15:0] ba, input logic [15:0] d);
        bit          dut_acc;
        logic [31:0] acc_word;
        imem_ready = ir; inst_ready = dr; branch_taken = bt; branch_addr = ba; imem_data = d;
        #1;
        dut_acc  = inst_valid && inst_ready;
        acc_word = {inst_pc, inst_out};
        @(posedge clk);
        model_edge();
        if (dut_acc) begin
            if (exp_q.size() == 0) check("accept_extra", 32'd1, 32'd0);
            else check("accept", acc_word, exp_q.pop_front());
        end
        #1;
        compare_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        compare_all();
        check("w_reset_addr", 32'(w_imem_addr), 32'hFFFF);
        check("w_reset_req",  32'(w_imem_req),  32'd0);

        // Startup with both sides always ready.
        step(1, 1, 0, 16'h0, 16'h1000);
        check("w_first_req", 32'(w_imem_req), 32'd1);
        step(1, 1, 0, 16'h0, 16'h1001);
        check("w_wrap_inst_pc", 32'(w_inst_pc),   32'hFFFF);
        check("w_wrap_addr",    32'(w_imem_addr), 32'h0000);
        check("w_wrap_valid",   32'(w_inst_valid), 32'd1);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 16'h0, 16'(16'h2000 + i));

        // Memory wait at pc 5.
        step(1, 1, 1, 16'h0005, 16'h0);
        step(1, 1, 0, 16'h0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 16'h0, 16'h0);
            check("wait_addr", 32'(imem_addr), 32'd5);
        end
        step(1, 1, 0, 16'h0, 16'h5555);
        check("wait_inst_pc", 32'(inst_pc), 32'd5);

        // Decode stall holding A5A5.
        step(1, 1, 0, 16'h0, 16'h0);
        step(1, 0, 0, 16'h0, 16'hA5A5);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 16'h0, 16'h0);
            check("stall_out", 32'(inst_out), 32'hA5A5);
            check("stall_pc_next", 32'(imem_addr), 32'(inst_pc + 16'd1));
        end

        // Redirect from HOLD with inst_pc 8.
        step(0, 1, 1, 16'h0008, 16'h0);
        step(1, 1, 0, 16'h0, 16'h0);
        step(1, 0, 0, 16'h0, 16'h0808);
        check("hold_pc8", 32'(inst_pc), 32'd8);
        step(0, 1, 1, 16'h0040, 16'h0);
        check("redir_flush", 32'(flush), 32'd1);
        step(0, 0, 0, 16'h0, 16'h0);
        check("redir_addr", 32'(imem_addr), 32'h0040);
        check("redir_flush_end", 32'(flush), 32'd0);

        // Redirect from FETCH coinciding with imem_ready, then back-to-back branches.
        step(1, 1, 1, 16'h0077, 16'hDEAD);
        check("drop_valid", 32'(inst_valid), 32'd0);
        step(0, 1, 1, 16'h0099, 16'h0);
        step(0, 1, 0, 16'h0, 16'h0);
        check("double_redir_addr", 32'(imem_addr), 32'h0099);

        // Wrap via branch to all-ones.
        step(0, 1, 1, 16'hFFFF, 16'h0);
        step(0, 1, 0, 16'h0, 16'h0);
        step(1, 0, 0, 16'h0, 16'h0F0F);
        check("wrap_inst_pc", 32'(inst_pc), 32'hFFFF);
        check("wrap_addr",    32'(imem_addr), 32'h0000);

        // Async reset while holding, away from any clock edge.
        #3 rst = 1'b1;
        #1;
        model_reset();
        check("arst_valid", 32'(inst_valid), 32'd0);
        check("arst_req",   32'(imem_req),   32'd0);
        check("arst_addr",  32'(imem_addr),  32'd0);
        check("arst_flush", 32'(flush),      32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        compare_all();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 11) == 0,
                 ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom),
                 16'($urandom));
        end

        check("accept_pending", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
